// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between instruction fetch and load/store.
// One outstanding access; misaligned or timed-out accesses answer with err instead of data.
module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic GRANT_LS = 1'b0;
    localparam logic GRANT_IF = 1'b1;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_reg;
    logic          last_grant_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   rdata_reg;
    logic          err_reg;

    logic          any_req;
    logic          win_if;
    logic          sel_we;
    logic [1:0]    sel_size;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic          misaligned;
    logic [3:0]    sel_be;
    logic [31:0]   sel_lanes;

    // On a tie the port that did not win last time goes first.
    assign any_req   = if_req | ls_req;
    assign win_if    = if_req & (~ls_req | (last_grant_reg == GRANT_LS));
    assign sel_we    = win_if ? 1'b0 : ls_we;
    assign sel_size  = win_if ? 2'd2 : ls_size;
    assign sel_addr  = win_if ? if_addr : ls_addr;
    assign sel_wdata = win_if ? 32'h0 : ls_wdata;

    always_comb begin
        misaligned = 1'b0;
        case (sel_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = sel_addr[0];
            2'd2:    misaligned = (sel_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Each byte lane decides its own enable and which source byte lands on it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       be_l;
            logic [7:0] data_l;

            always_comb begin
                be_l   = 1'b0;
                data_l = 8'h00;
                case (sel_size)
                    2'd0: begin
                        be_l   = (sel_addr[1:0] == LANE);
                        data_l = sel_wdata[7:0];
                    end
                    2'd1: begin
                        be_l   = (sel_addr[1] == LANE[1]);
                        data_l = sel_wdata[8*(gi%2) +: 8];
                    end
                    2'd2: begin
                        be_l   = 1'b1;
                        data_l = sel_wdata[8*gi +: 8];
                    end
                    default: begin
                        be_l   = 1'b0;
                        data_l = 8'h00;
                    end
                endcase
            end

            assign sel_be[gi]           = be_l;
            assign sel_lanes[8*gi +: 8] = be_l ? data_l : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= GRANT_LS;
            count_reg      <= '0;
            rdata_reg      <= 32'h0;
            err_reg        <= 1'b0;
            if_gnt         <= 1'b0;
            if_rvalid      <= 1'b0;
            if_rdata       <= 32'h0;
            if_err         <= 1'b0;
            ls_gnt         <= 1'b0;
            ls_rvalid      <= 1'b0;
            ls_rdata       <= 32'h0;
            ls_err         <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_be         <= 4'h0;
            mem_addr       <= 32'h0;
            mem_wdata      <= 32'h0;
            busy           <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        last_grant_reg <= win_if ? GRANT_IF : GRANT_LS;
                        if_gnt         <= win_if;
                        ls_gnt         <= ~win_if;
                        mem_addr       <= {sel_addr[31:2], 2'b00};
                        mem_be         <= sel_be;
                        mem_wdata      <= sel_lanes;
                        count_reg      <= '0;
                        busy           <= 1'b1;
                        if (misaligned) begin
                            state_reg <= ST_RESP;
                            err_reg   <= 1'b1;
                            rdata_reg <= 32'h0;
                        end else begin
                            state_reg <= ST_BUSY;
                            mem_req   <= 1'b1;
                            mem_we    <= sel_we;
                        end
                    end
                end
                ST_BUSY: begin
                    // A ready arriving on the final allowed cycle still counts as success.
                    if (mem_ready) begin
                        rdata_reg <= mem_rdata;
                        err_reg   <= 1'b0;
                        count_reg <= '0;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        state_reg <= ST_RESP;
                    end else if (count_reg == COUNT_LAST) begin
                        rdata_reg <= 32'h0;
                        err_reg   <= 1'b1;
                        count_reg <= '0;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        state_reg <= ST_RESP;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (last_grant_reg == GRANT_IF) begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= rdata_reg;
                        if_err    <= err_reg;
                    end else begin
                        ls_rvalid <= 1'b1;
                        ls_rdata  <= rdata_reg;
                        ls_err    <= err_reg;
                    end
                    count_reg <= '0;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
